// File: rtl/clk_div_switch_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_switch_pkg
// Shared types and constants for the glitch-free divided-clock switch.
//   state_e  : switch FSM states (START, RUN, PEND, GAP)
//   MIN_DIV  : smallest effective divisor; raw divisors below it are promoted
//   eff_div  : maps a raw programmed divisor onto the effective divisor
// -----------------------------------------------------------------------------
package clk_div_switch_pkg;

  typedef enum logic [1:0] {
    ST_START = 2'd0,  // first edge after reset release
    ST_RUN   = 2'd1,  // free-running on the current channel
    ST_PEND  = 2'd2,  // running, a channel request is latched
    ST_GAP   = 2'd3   // forced-low dead time between old and new source
  } state_e;

  localparam int unsigned MIN_DIV = 2;

  // Divisors 0 and 1 cannot produce both a high and a low phase, so they
  // run as the smallest legal divisor instead.
  function automatic int unsigned eff_div(input int unsigned raw);
    return (raw < MIN_DIV) ? MIN_DIV : raw;
  endfunction

endpackage : clk_div_switch_pkg

// File: rtl/clk_div_switch_phase_cnt.sv
// -----------------------------------------------------------------------------
// clk_div_switch_phase_cnt
// Phase counter and output flops for one divided-clock stream.
// A load starts a new period at phase 0 with a freshly latched divisor;
// an advance steps the phase; with neither the outputs are held low and
// the phase is frozen (used for reset release and the dead gap).
//
// Ports:
//   clk, rst    : system clock, synchronous active-high reset
//   load_i      : start a new period using div_i (latched this edge)
//   adv_i       : advance phase by one inside the current period
//   div_i       : raw divisor of the channel to load
//   wrap_o      : current phase is the last of the period (D-1)
//   clk_div_o   : divided clock level (flop output)
//   clk_en_o    : one-cycle pulse on the first cycle of each period
// -----------------------------------------------------------------------------
module clk_div_switch_phase_cnt
  import clk_div_switch_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             adv_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             wrap_o,
  output logic             clk_div_o,
  output logic             clk_en_o
);

  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] d_q, d_d;
  logic             clk_div_q, clk_div_d;
  logic             clk_en_q, clk_en_d;

  logic [CNT_W-1:0] h_cur;   // high-phase length of the running period
  logic [CNT_W-1:0] d_new;   // effective divisor being loaded
  logic [CNT_W-1:0] h_new;   // high-phase length of the period being loaded

  assign h_cur  = d_q >> 1;
  assign d_new  = CNT_W'(eff_div(32'(div_i)));
  assign h_new  = d_new >> 1;
  assign wrap_o = (phase_q == (d_q - CNT_W'(1)));

  always_comb begin
    phase_d   = phase_q;
    d_d       = d_q;
    clk_div_d = 1'b0;
    clk_en_d  = 1'b0;
    if (load_i) begin
      phase_d   = '0;
      d_d       = d_new;
      clk_en_d  = 1'b1;
      clk_div_d = (h_new != '0);
    end else if (adv_i) begin
      phase_d   = phase_q + CNT_W'(1);
      clk_div_d = (phase_d < h_cur);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= '0;
      d_q       <= CNT_W'(MIN_DIV);
      clk_div_q <= 1'b0;
      clk_en_q  <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      d_q       <= d_d;
      clk_div_q <= clk_div_d;
      clk_en_q  <= clk_en_d;
    end
  end

  assign clk_div_o = clk_div_q;
  assign clk_en_o  = clk_en_q;

endmodule : clk_div_switch_phase_cnt

// File: rtl/clk_div_switch.sv
// -----------------------------------------------------------------------------
// clk_div_switch
// Single-clock divided-clock generator selecting one of NUM_SEL programmable
// divisors. Channel changes take effect only at a period boundary (output
// low), optionally followed by GAP_CYCLES forced-low cycles, so the divided
// clock never shows a runt pulse.
//
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   div_i        : packed divisors, channel k at [k*CNT_W +: CNT_W]
//   sel_i        : requested channel (clamped to NUM_SEL-1)
//   sel_valid_i  : request strobe, accepted only while busy_o is low
//   clk_div_o    : divided clock level
//   clk_en_o     : one-cycle pulse on the first cycle of each period
//   cur_sel_o    : channel currently in effect
//   sel_ack_o    : one-cycle pulse when a requested channel takes effect
//   busy_o       : a request is pending or the dead gap is running
// -----------------------------------------------------------------------------
module clk_div_switch
  import clk_div_switch_pkg::*;
#(
  parameter int unsigned NUM_SEL    = 4,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned SEL_W      = $clog2(NUM_SEL)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SEL*CNT_W-1:0] div_i,
  input  logic [SEL_W-1:0]         sel_i,
  input  logic                     sel_valid_i,
  output logic                     clk_div_o,
  output logic                     clk_en_o,
  output logic [SEL_W-1:0]         cur_sel_o,
  output logic                     sel_ack_o,
  output logic                     busy_o
);

  localparam bit          HAS_GAP  = (GAP_CYCLES != 0);
  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LOAD = HAS_GAP ? (GAP_CYCLES - 1) : 0;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] req_q, req_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;

  logic             wrap;
  logic             load;
  logic             adv;
  logic             switch_sel;
  logic             accept;
  logic [SEL_W-1:0] sel_clamp;
  logic [SEL_W-1:0] load_sel;
  logic [CNT_W-1:0] load_div;
  int unsigned      sel_int;

  // Out-of-range requests (non power-of-two NUM_SEL) map to the top channel.
  always_comb begin
    sel_int   = 32'(sel_i);
    sel_clamp = sel_i;
    if (sel_int > NUM_SEL - 1) sel_clamp = SEL_W'(NUM_SEL - 1);
  end

  assign accept = (state_q == ST_RUN) && sel_valid_i && !busy_q;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_START;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // A request accepted on a wrap edge only moves RUN->PEND; the wrap itself
  // restarts the old channel, so the switch lands on the following wrap.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_START: state_d = ST_RUN;
      ST_RUN:   if (accept) state_d = ST_PEND;
      ST_PEND: begin
        if (wrap) begin
          if ((req_q == cur_sel_q) || !HAS_GAP) state_d = ST_RUN;
          else                                  state_d = ST_GAP;
        end
      end
      ST_GAP:   if (gap_q == '0) state_d = ST_RUN;
      default:  state_d = ST_START;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (phase-counter controls and switch strobes)
  // ---------------------------------------------------------------------------
  always_comb begin
    load       = 1'b0;
    adv        = 1'b0;
    ack_d      = 1'b0;
    switch_sel = 1'b0;
    unique case (state_q)
      ST_START: load = 1'b1;
      ST_RUN: begin
        if (wrap) load = 1'b1;
        else      adv  = 1'b1;
      end
      ST_PEND: begin
        if (wrap) begin
          // Same-channel requests skip the gap: the source does not change.
          if ((req_q == cur_sel_q) || !HAS_GAP) begin
            load       = 1'b1;
            ack_d      = 1'b1;
            switch_sel = 1'b1;
          end
        end else begin
          adv = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          load       = 1'b1;
          ack_d      = 1'b1;
          switch_sel = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy_d   = (state_d == ST_PEND) || (state_d == ST_GAP);
  assign load_sel = switch_sel ? req_q : cur_sel_q;
  assign load_div = div_i[int'(load_sel)*CNT_W +: CNT_W];

  // ---------------------------------------------------------------------------
  // Request latch, current selection and gap counter
  // ---------------------------------------------------------------------------
  always_comb begin
    req_d     = req_q;
    cur_sel_d = cur_sel_q;
    gap_d     = gap_q;
    if (accept)     req_d     = sel_clamp;
    if (switch_sel) cur_sel_d = req_q;
    if ((state_q == ST_PEND) && (state_d == ST_GAP)) gap_d = GAP_W'(GAP_LOAD);
    else if ((state_q == ST_GAP) && (gap_q != '0))   gap_d = gap_q - GAP_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q     <= '0;
      cur_sel_q <= '0;
      gap_q     <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      req_q     <= req_d;
      cur_sel_q <= cur_sel_d;
      gap_q     <= gap_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Phase counter / output flops
  // ---------------------------------------------------------------------------
  clk_div_switch_phase_cnt #(
    .CNT_W (CNT_W)
  ) u_phase_cnt (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .adv_i     (adv),
    .div_i     (load_div),
    .wrap_o    (wrap),
    .clk_div_o (clk_div_o),
    .clk_en_o  (clk_en_o)
  );

  assign cur_sel_o = cur_sel_q;
  assign sel_ack_o = ack_q;
  assign busy_o    = busy_q;

endmodule : clk_div_switch
